memory_arbiter: RTL and testbench
=================================

Name: memory_arbiter

Overview:
- Shares the single memory interface port (word address, write data, read strobe, active-low write strobe, read data) between the instruction-fetch path and the load/store path of the core.
- Arbitrates between the two requesters, sequences the strobes with guaranteed setup/hold cycles, checks alignment, and returns registered responses via a request/ack handshake.

Parameters:
- READ_LATENCY, 1, cycles between strobe cycle and read-data capture (legal 1..7)
- ADDR_SHIFT, 2, right shift converting byte address to memory word index
- FIXED_PRIORITY, 0, 0 = round-robin; 1 = data port always wins ties

Ports:
- clk  input  1  clock, all logic on rising edge
- reset  input  1  synchronous, active-low reset
- instr_request  input  1  fetch request, held until instr_ack
- instr_address  input  32  fetch byte address
- instr_ack  output  1  one-cycle completion pulse
- instr_error  output  1  misaligned fetch; valid with instr_ack
- instr_read_data  output  32  fetched word; valid with instr_ack
- data_request  input  1  load/store request, held until data_ack
- data_write  input  1  1 = store, 0 = load
- data_address  input  32  load/store byte address
- data_write_data  input  32  store data
- data_ack  output  1  one-cycle completion pulse
- data_error  output  1  misaligned access; valid with data_ack
- data_read_data  output  32  load data; valid with data_ack
- mem_address  output  32  word index = byte address >> ADDR_SHIFT
- mem_write_data  output  32  write data to memory
- mem_read_enable  output  1  active-high read strobe
- mem_write_enable  output  1  active-low write strobe; idle high; memory writes on falling edge
- mem_read_data  input  32  memory read data

Behaviour:
- Reset: the clock edge with reset=0 forces:
  - state IDLE;
  - all acks/errors 0, read_data outputs 0;
  - mem_address 0, mem_write_data 0, mem_read_enable 0, mem_write_enable 1;
  - last_grant = DATA, so the instruction port wins the first tie.
  - An in-flight transaction is dropped with no ack. The requester must re-request.
- All outputs are registered. No combinational path from inputs to outputs.
- States: IDLE, SETUP, STROBE, WAIT, DONE.
- IDLE:
  - If any request is high, pick the winner, latch address/data/write/port ID, update last_grant.
  - If address[1:0] != 0: go to DONE with error=1, no memory access.
  - Otherwise go to SETUP.
- Arbitration: a single request wins outright. On a tie, round-robin grants the port not in last_grant; with FIXED_PRIORITY=1, data always wins.
- SETUP: drive mem_address and mem_write_data, strobes idle. Goes to STROBE.
- STROBE:
  - For a read, mem_read_enable=1 for exactly one cycle, then go to WAIT.
  - For a write, mem_write_enable=0 for exactly one cycle, then go to DONE.
  - mem_address/mem_write_data stay stable from SETUP through the cycle after STROBE.
- WAIT: count READ_LATENCY cycles. Capture mem_read_data on the last WAIT cycle into the port's read_data register, then go to DONE.
- DONE: assert the granted port's ack for 1 cycle (error if misaligned), strobes idle, then go to IDLE.
- Latency, request seen in IDLE at T0:
  - aligned read ack at T0+3+READ_LATENCY (T0+4 at default);
  - write ack at T0+3;
  - misaligned ack at T0+1.
- Handshake:
  - Requester holds request and payload stable until ack.
  - A request still high in the IDLE cycle after DONE is a new transaction. Requesters drop request the cycle after ack.
  - Payload changes before ack are ignored, because it is latched in IDLE.
- Ungranted requester stays pending with no ack; it wins the next IDLE tie under round-robin.
- read_data outputs hold their last value until the next completed read for that port. They are not updated on writes or on errors.
- Errored transactions return read_data unchanged.
- Address wrap: the word index is a plain shift; upper bits pass through unmodified. Range checking is the memory's responsibility.

Decomposition:
- Shared constants include file memory_arbiter_defines.vh holds:
  - state encodings (IDLE=0 .. DONE=4);
  - port IDs (PORT_INSTR=0, PORT_DATA=1);
  - strobe idle levels.
- One sub-module: arbiter_round_robin_picker. Inputs: two requests, last_grant, FIXED_PRIORITY. Outputs: grant valid and grant ID. Purely combinational.
- FSM, latency counter and datapath registers stay in memory_arbiter.

Test Plan:
- Reset=0 for 2 cycles during a read in STROBE -> next cycle mem_read_enable=0, mem_write_enable=1, no ack ever. After release, instr read of 0x10 completes normally.
- Data store 0x0000_0008 <- 0xDEADBEEF, then load 0x8 -> mem_address=2, mem_write_enable low exactly 1 cycle, store ack at T0+3. Load returns 0xDEADBEEF at T0+4.
- Both requests high continuously after reset (RR) -> grant order instr, data, instr, data. Each ack only to the granted port, none overlapping.
- FIXED_PRIORITY=1, both high -> data served until data_request drops, then instr.
- Instr fetch at 0x0000_0006 -> instr_ack and instr_error at T0+1, no strobe toggles, instr_read_data unchanged.
- READ_LATENCY=3, memory model delays data by 3 cycles -> ack at T0+6 with correct word; mem_address stable through capture.

Source files
------------

// File: rtl/memory_arbiter_pkg.sv
// Shared types and constants for the memory arbiter slice.
package memory_arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        STROBE = 3'd2,
        WAIT   = 3'd3,
        DONE   = 3'd4
    } arb_state_t;

    typedef enum logic {
        PORT_INSTR = 1'b0,
        PORT_DATA  = 1'b1
    } port_id_t;

    // Strobe levels while no memory access is in progress
    localparam logic READ_STROBE_IDLE  = 1'b0;
    localparam logic WRITE_STROBE_IDLE = 1'b1;

    function automatic logic is_misaligned(input logic [31:0] byte_address);
        return byte_address[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/memory_arbiter_round_robin_picker.sv
// Two-way request picker: round-robin on ties, or data-wins when FIXED_PRIORITY is set.
module arbiter_round_robin_picker
    import memory_arbiter_pkg::*;
#(
    parameter int FIXED_PRIORITY = 0
) (
    input  logic     instr_request,
    input  logic     data_request,
    input  port_id_t last_grant,
    output logic     grant_valid,
    output port_id_t grant_id
);

    // Single requester wins outright; a tie goes to the port not granted last time
    always_comb begin
        grant_valid = instr_request | data_request;
        grant_id    = PORT_INSTR;
        if (instr_request && data_request) begin
            if (FIXED_PRIORITY != 0)
                grant_id = PORT_DATA;
            else
                grant_id = (last_grant == PORT_DATA) ? PORT_INSTR : PORT_DATA;
        end else if (data_request) begin
            grant_id = PORT_DATA;
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// Shares one memory port between instruction fetch and load/store with registered responses.
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int READ_LATENCY   = 1,
    parameter int ADDR_SHIFT     = 2,
    parameter int FIXED_PRIORITY = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_request,
    input  logic [31:0] instr_address,
    output logic        instr_ack,
    output logic        instr_error,
    output logic [31:0] instr_read_data,
    input  logic        data_request,
    input  logic        data_write,
    input  logic [31:0] data_address,
    input  logic [31:0] data_write_data,
    output logic        data_ack,
    output logic        data_error,
    output logic [31:0] data_read_data,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_read_enable,
    output logic        mem_write_enable,
    input  logic [31:0] mem_read_data
);

    arb_state_t  state;
    port_id_t    last_grant;
    port_id_t    cur_port;
    logic        cur_write;
    logic [2:0]  wait_count;
    logic        grant_valid;
    port_id_t    grant_id;
    logic [31:0] sel_address;
    logic [31:0] sel_write_data;
    logic        sel_write;

    arbiter_round_robin_picker #(
        .FIXED_PRIORITY(FIXED_PRIORITY)
    ) u_picker (
        .instr_request(instr_request),
        .data_request (data_request),
        .last_grant   (last_grant),
        .grant_valid  (grant_valid),
        .grant_id     (grant_id)
    );

    // Route the winning requester's payload toward the IDLE latch
    always_comb begin
        sel_address    = instr_address;
        sel_write_data = '0;
        sel_write      = 1'b0;
        if (grant_id == PORT_DATA) begin
            sel_address    = data_address;
            sel_write_data = data_write_data;
            sel_write      = data_write;
        end
    end

    // Transaction sequencer: grant latch, strobe timing, read latency count, responses
    always_ff @(posedge clk) begin
        if (!reset) begin
            state            <= IDLE;
            last_grant       <= PORT_DATA;
            cur_port         <= PORT_INSTR;
            cur_write        <= 1'b0;
            wait_count       <= '0;
            instr_ack        <= 1'b0;
            instr_error      <= 1'b0;
            instr_read_data  <= '0;
            data_ack         <= 1'b0;
            data_error       <= 1'b0;
            data_read_data   <= '0;
            mem_address      <= '0;
            mem_write_data   <= '0;
            mem_read_enable  <= READ_STROBE_IDLE;
            mem_write_enable <= WRITE_STROBE_IDLE;
        end else begin
            instr_ack   <= 1'b0;
            instr_error <= 1'b0;
            data_ack    <= 1'b0;
            data_error  <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        cur_port   <= grant_id;
                        cur_write  <= sel_write;
                        last_grant <= grant_id;
                        if (is_misaligned(sel_address)) begin
                            // Answer from DONE next cycle; memory side stays untouched
                            instr_ack   <= (grant_id == PORT_INSTR);
                            instr_error <= (grant_id == PORT_INSTR);
                            data_ack    <= (grant_id == PORT_DATA);
                            data_error  <= (grant_id == PORT_DATA);
                            state       <= DONE;
                        end else begin
                            mem_address    <= sel_address >> ADDR_SHIFT;
                            mem_write_data <= sel_write_data;
                            state          <= SETUP;
                        end
                    end
                end
                SETUP: begin
                    if (cur_write)
                        mem_write_enable <= ~WRITE_STROBE_IDLE;
                    else
                        mem_read_enable  <= ~READ_STROBE_IDLE;
                    state <= STROBE;
                end
                STROBE: begin
                    mem_read_enable  <= READ_STROBE_IDLE;
                    mem_write_enable <= WRITE_STROBE_IDLE;
                    if (cur_write) begin
                        instr_ack <= (cur_port == PORT_INSTR);
                        data_ack  <= (cur_port == PORT_DATA);
                        state     <= DONE;
                    end else begin
                        wait_count <= 3'(READ_LATENCY - 1);
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    if (wait_count == '0) begin
                        if (cur_port == PORT_INSTR)
                            instr_read_data <= mem_read_data;
                        else
                            data_read_data  <= mem_read_data;
                        instr_ack <= (cur_port == PORT_INSTR);
                        data_ack  <= (cur_port == PORT_DATA);
                        state     <= DONE;
                    end else begin
                        wait_count <= wait_count - 3'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Randomised bench for memory_arbiter: three instances (RR/RL1, fixed/RL1, RR/RL3) against a transaction-level model.
module tb_memory_arbiter;

    localparam int NI = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset           [NI];
    logic        instr_request   [NI];
    logic [31:0] instr_address   [NI];
    logic        instr_ack       [NI];
    logic        instr_error     [NI];
    logic [31:0] instr_read_data [NI];
    logic        data_request    [NI];
    logic        data_write      [NI];
    logic [31:0] data_address    [NI];
    logic [31:0] data_write_data [NI];
    logic        data_ack        [NI];
    logic        data_error      [NI];
    logic [31:0] data_read_data  [NI];
    logic [31:0] mem_address     [NI];
    logic [31:0] mem_write_data  [NI];
    logic        mem_read_enable [NI];
    logic        mem_write_enable[NI];
    logic [31:0] mem_read_data   [NI];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic int rl_of(input int k);
        return (k == 2) ? 3 : 1;
    endfunction

    function automatic logic [31:0] init_word(input int k, input int i);
        return 32'hA500_0000 ^ (32'(k) << 20) ^ (32'(i) * 32'h0001_0203);
    endfunction

    memory_arbiter #(.READ_LATENCY(1), .ADDR_SHIFT(2), .FIXED_PRIORITY(0)) u_dut0 (
        .clk(clk), .reset(reset[0]),
        .instr_request(instr_request[0]), .instr_address(instr_address[0]), .instr_ack(instr_ack[0]),
        .instr_error(instr_error[0]), .instr_read_data(instr_read_data[0]),
        .data_request(data_request[0]), .data_write(data_write[0]), .data_address(data_address[0]),
        .data_write_data(data_write_data[0]), .data_ack(data_ack[0]), .data_error(data_error[0]),
        .data_read_data(data_read_data[0]), .mem_address(mem_address[0]), .mem_write_data(mem_write_data[0]),
        .mem_read_enable(mem_read_enable[0]), .mem_write_enable(mem_write_enable[0]), .mem_read_data(mem_read_data[0])
    );

    memory_arbiter #(.READ_LATENCY(1), .ADDR_SHIFT(2), .FIXED_PRIORITY(1)) u_dut1 (
        .clk(clk), .reset(reset[1]),
        .instr_request(instr_request[1]), .instr_address(instr_address[1]), .instr_ack(instr_ack[1]),
        .instr_error(instr_error[1]), .instr_read_data(instr_read_data[1]),
        .data_request(data_request[1]), .data_write(data_write[1]), .data_address(data_address[1]),
        .data_write_data(data_write_data[1]), .data_ack(data_ack[1]), .data_error(data_error[1]),
        .data_read_data(data_read_data[1]), .mem_address(mem_address[1]), .mem_write_data(mem_write_data[1]),
        .mem_read_enable(mem_read_enable[1]), .mem_write_enable(mem_write_enable[1]), .mem_read_data(mem_read_data[1])
    );

    memory_arbiter #(.READ_LATENCY(3), .ADDR_SHIFT(2), .FIXED_PRIORITY(0)) u_dut2 (
        .clk(clk), .reset(reset[2]),
        .instr_request(instr_request[2]), .instr_address(instr_address[2]), .instr_ack(instr_ack[2]),
        .instr_error(instr_error[2]), .instr_read_data(instr_read_data[2]),
        .data_request(data_request[2]), .data_write(data_write[2]), .data_address(data_address[2]),
        .data_write_data(data_write_data[2]), .data_ack(data_ack[2]), .data_error(data_error[2]),
        .data_read_data(data_read_data[2]), .mem_address(mem_address[2]), .mem_write_data(mem_write_data[2]),
        .mem_read_enable(mem_read_enable[2]), .mem_write_enable(mem_write_enable[2]), .mem_read_data(mem_read_data[2])
    );

    // Memory environment: 64-word store, read data delayed by the instance's latency, strobe/address monitors
    bit          armed = 1'b0;
    logic [31:0] env_mem     [NI][64];
    bit          env_written [NI][64];
    logic [31:0] pipe        [NI][8];
    int          re_cnt      [NI];
    int          we_cnt      [NI];
    int          addr_chg    [NI];
    logic [31:0] last_addr   [NI];

    always @(posedge clk) begin
        for (int k = 0; k < NI; k++) begin
            if (armed) begin
                if (mem_write_enable[k] === 1'b0) begin
                    env_mem[k][mem_address[k][5:0]]     <= mem_write_data[k];
                    env_written[k][mem_address[k][5:0]] <= 1'b1;
                    we_cnt[k] <= we_cnt[k] + 1;
                end
                if (mem_read_enable[k] === 1'b1) begin
                    re_cnt[k] <= re_cnt[k] + 1;
                    pipe[k][0] <= env_written[k][mem_address[k][5:0]] ? env_mem[k][mem_address[k][5:0]]
                                                                        : init_word(k, int'(mem_address[k][5:0]));
                end else begin
                    pipe[k][0] <= $urandom;
                end
                for (int j = 1; j < 8; j++) pipe[k][j] <= pipe[k][j-1];
                if (mem_address[k] !== last_addr[k]) addr_chg[k] <= addr_chg[k] + 1;
                last_addr[k] <= mem_address[k];
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NI; k++) mem_read_data[k] = pipe[k][rl_of(k) - 1];
    end

    // Reference model state
    logic [31:0] ref_mem [NI][64];
    logic [31:0] exp_ird [NI];
    logic [31:0] exp_drd [NI];

    task automatic check_reset_state(input int k);
        string t;
        t = $sformatf("u%0d reset", k);
        check({t, " instr_ack"},        instr_ack[k],        0);
        check({t, " instr_error"},      instr_error[k],      0);
        check({t, " data_ack"},         data_ack[k],         0);
        check({t, " data_error"},       data_error[k],       0);
        check({t, " instr_read_data"},  instr_read_data[k],  0);
        check({t, " data_read_data"},   data_read_data[k],   0);
        check({t, " mem_address"},      mem_address[k],      0);
        check({t, " mem_write_data"},   mem_write_data[k],   0);
        check({t, " mem_read_enable"},  mem_read_enable[k],  0);
        check({t, " mem_write_enable"}, mem_write_enable[k], 1);
    endtask

    task automatic do_reset(input int k);
        reset[k] = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_state(k);
        reset[k] = 1'b1;
        exp_ird[k] = '0;
        exp_drd[k] = '0;
    endtask

    // One transaction from an otherwise idle arbiter; checks latency, response, strobes and address
    task automatic xfer(input int k, input bit is_data, input bit wr, input logic [31:0] addr, input logic [31:0] wd);
        bit          mis, seen;
        int          lat, exp_lat, re0, we0, ac0, wrong_ack;
        logic [5:0]  idx;
        logic        got_err;
        string       t;
        mis = (addr[1:0] != 2'b00);
        idx = addr[7:2];
        t = $sformatf("u%0d %s@%08h", k, is_data ? (wr ? "st" : "ld") : "if", addr);
        exp_lat = mis ? 1 : (wr ? 3 : 3 + rl_of(k));
        if (is_data) begin
            data_request[k] = 1'b1; data_write[k] = wr; data_address[k] = addr; data_write_data[k] = wd;
        end else begin
            instr_request[k] = 1'b1; instr_address[k] = addr;
        end
        re0 = re_cnt[k];
        we0 = we_cnt[k];
        ac0 = addr_chg[k];
        lat = 0; seen = 1'b0; wrong_ack = 0;
        while (!seen && lat < 20) begin
            @(negedge clk);
            lat++;
            if (lat == 2) ac0 = addr_chg[k];
            if (is_data ? instr_ack[k] : data_ack[k]) wrong_ack++;
            seen = is_data ? data_ack[k] : instr_ack[k];
            if (!seen) begin
                if (is_data) begin
                    data_address[k] = $urandom; data_write_data[k] = $urandom; data_write[k] = ~wr;
                end else begin
                    instr_address[k] = $urandom;
                end
            end
        end
        if (is_data) data_request[k] = 1'b0; else instr_request[k] = 1'b0;
        check({t, " latency"}, lat, exp_lat);
        check({t, " wrong-port ack"}, wrong_ack, 0);
        if (!mis) begin
            if (wr) ref_mem[k][idx] = wd;
            else if (is_data) exp_drd[k] = ref_mem[k][idx];
            else exp_ird[k] = ref_mem[k][idx];
        end
        got_err = is_data ? data_error[k] : instr_error[k];
        check({t, " error"}, got_err, mis);
        check({t, " instr_read_data"}, instr_read_data[k], exp_ird[k]);
        check({t, " data_read_data"}, data_read_data[k], exp_drd[k]);
        check({t, " read strobes"}, re_cnt[k] - re0, (!mis && !wr));
        check({t, " write strobes"}, we_cnt[k] - we0, (!mis && wr));
        if (!mis) begin
            check({t, " mem_address"}, mem_address[k], addr >> 2);
            check({t, " address stable"}, addr_chg[k] - ac0, 0);
            if (wr) check({t, " mem_write_data"}, mem_write_data[k], wd);
        end
        @(negedge clk);
        check({t, " ack pulse width"}, is_data ? data_ack[k] : instr_ack[k], 0);
    endtask

    // Both ports loading continuously; data drops its request after data_stop grants (0 = never)
    task automatic tie_run(input int k, input int n_acks, input int data_stop);
        int got[$];
        int exp_q[$];
        int last_d, dcount, overlap, cyc;
        bit dreq, fixed;
        string t;
        t = $sformatf("u%0d tie", k);
        fixed = (k == 1);
        last_d = 1; dreq = 1'b1; dcount = 0;
        for (int i = 0; i < n_acks; i++) begin
            int w;
            if (dreq) w = fixed ? 1 : (last_d == 1 ? 0 : 1);
            else w = 0;
            exp_q.push_back(w);
            last_d = w;
            if (w == 1) begin
                dcount++;
                if (dcount == data_stop) dreq = 1'b0;
            end
        end
        instr_request[k] = 1'b1; instr_address[k] = 32'h0000_0020;
        data_request[k] = 1'b1; data_write[k] = 1'b0; data_address[k] = 32'h0000_0040;
        dcount = 0; overlap = 0; cyc = 0;
        while (got.size() < n_acks && cyc < 40 * n_acks) begin
            @(negedge clk);
            cyc++;
            if (instr_ack[k] && data_ack[k]) overlap++;
            if (instr_ack[k]) begin
                got.push_back(0);
                check({t, " instr word"}, instr_read_data[k], ref_mem[k][8]);
            end
            if (data_ack[k]) begin
                got.push_back(1);
                check({t, " data word"}, data_read_data[k], ref_mem[k][16]);
                dcount++;
                if (dcount == data_stop) data_request[k] = 1'b0;
            end
        end
        instr_request[k] = 1'b0;
        data_request[k]  = 1'b0;
        check({t, " ack count"}, got.size(), n_acks);
        check({t, " overlapping acks"}, overlap, 0);
        for (int i = 0; i < n_acks; i++)
            check($sformatf("%s grant %0d (0=instr 1=data)", t, i), (i < got.size()) ? got[i] : -1, exp_q[i]);
        exp_ird[k] = ref_mem[k][8];
        exp_drd[k] = ref_mem[k][16];
        repeat (2) @(negedge clk);
    endtask

    task automatic reset_mid_read(input int k);
        int cyc, acks;
        cyc = 0; acks = 0;
        instr_request[k] = 1'b1; instr_address[k] = 32'h0000_0010;
        while (mem_read_enable[k] !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("mid-read reset reached strobe", mem_read_enable[k], 1);
        reset[k] = 1'b0;
        instr_request[k] = 1'b0;
        @(negedge clk);
        check("mid-read reset mem_read_enable", mem_read_enable[k], 0);
        check("mid-read reset mem_write_enable", mem_write_enable[k], 1);
        @(negedge clk);
        check_reset_state(k);
        reset[k] = 1'b1;
        exp_ird[k] = '0;
        exp_drd[k] = '0;
        repeat (8) begin
            @(negedge clk);
            if (instr_ack[k] || data_ack[k]) acks++;
        end
        check("mid-read reset stray acks", acks, 0);
        xfer(k, 1'b0, 1'b0, 32'h0000_0010, '0);
    endtask

    initial begin
        for (int k = 0; k < NI; k++) begin
            reset[k] = 1'b0;
            instr_request[k] = 1'b0; instr_address[k] = '0;
            data_request[k] = 1'b0; data_write[k] = 1'b0; data_address[k] = '0; data_write_data[k] = '0;
            exp_ird[k] = '0; exp_drd[k] = '0;
            for (int i = 0; i < 64; i++) ref_mem[k][i] = init_word(k, i);
        end
        repeat (2) @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            check_reset_state(k);
            reset[k] = 1'b1;
        end
        armed = 1'b1;

        xfer(0, 1'b1, 1'b1, 32'h0000_0008, 32'hDEAD_BEEF);
        xfer(0, 1'b1, 1'b0, 32'h0000_0008, '0);
        reset_mid_read(0);
        xfer(0, 1'b0, 1'b0, 32'h0000_0006, '0);
        xfer(0, 1'b1, 1'b1, 32'h0000_0002, 32'h1234_5678);
        xfer(0, 1'b1, 1'b0, 32'hFFFF_FF0C, '0);

        xfer(2, 1'b0, 1'b0, 32'h0000_0044, '0);
        xfer(2, 1'b1, 1'b1, 32'h0000_0044, 32'h0BAD_F00D);
        xfer(2, 1'b1, 1'b0, 32'h0000_0044, '0);

        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 30; i++) begin
                bit          d, w;
                logic [31:0] a;
                d = 1'($urandom_range(0, 1));
                w = d & 1'($urandom_range(0, 1));
                a = ($urandom & 32'hFFFF_FF00) | (32'($urandom_range(0, 63)) << 2);
                if ($urandom_range(0, 5) == 0) a[1:0] = 2'($urandom_range(1, 3));
                xfer(r * 2, d, w, a, $urandom);
            end
        end

        do_reset(0);
        tie_run(0, 4, 0);
        do_reset(1);
        tie_run(1, 4, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached before the end of test");
        $fatal(1, "watchdog");
    end

endmodule
